pong_score_keeper: RTL and testbench

Upstream scoring stage for the score display: converts goal events from the ball/collision logic into the two 4-bit BCD-range scores that drive the 7-segment refresh stage. It also sequences the post-goal serve pause, detects end of game and handles a debounced new-game button. All logic runs in the single system clock domain; scores are held stable between goals so the display multiplexer can sample them at any time.

---
 rtl/pong_score_keeper.sv | 190 +++++++++++++++++++
 tb/tb_pong_score_keeper.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
// pong_score_keeper
//   Turns goal events from the ball/collision logic into two 4-bit scores
//   for the 7-segment stage. It also sequences the post-goal serve pause,
//   detects the end of the game and accepts a debounced new-game button.
//
// Ports
//   CLK, RST_N          system clock; asynchronous active-low reset
//   p1_goal, p2_goal    goal levels (synchronous); only the rising edge counts
//   new_game            raw asynchronous push-button, active-high
//   p1_score, p2_score  scores, 0..WIN_SCORE, stable between goals
//   serve_req           one-cycle pulse that launches the ball
//   serve_dir           next serve direction: 0 toward p1, 1 toward p2
//   game_over           high while the game is finished
//   winner              00 none, 01 player 1, 10 player 2
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE       = 9,
  parameter int unsigned SERVE_DELAY     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       p1_goal,
  input  logic       p2_goal,
  input  logic       new_game,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       serve_req,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned PW = $clog2(SERVE_DELAY + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PAUSE_FIRST = PW'(1);
  localparam logic [PW-1:0] PAUSE_LAST  = PW'(SERVE_DELAY);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    WIN         = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pause_q, pause_d;
  logic [3:0]      p1_score_q, p1_score_d;
  logic [3:0]      p2_score_q, p2_score_d;
  logic            serve_req_q, serve_req_d;
  logic            serve_dir_q, serve_dir_d;
  logic [1:0]      winner_q, winner_d;

  logic            p1_goal_q, p2_goal_q;
  logic            ng_sync1_q, ng_sync2_q;
  logic            ng_filt_q, ng_filt_d;
  logic            ng_prev_q;
  logic [DW-1:0]   deb_q, deb_d;

  logic            p1_edge, p2_edge, ng_clear, pause_done;
  logic [3:0]      p1_inc, p2_inc;

  assign p1_edge    = p1_goal & ~p1_goal_q;
  assign p2_edge    = p2_goal & ~p2_goal_q;
  assign ng_clear   = ng_filt_q & ~ng_prev_q;
  assign pause_done = (pause_q == PAUSE_LAST);
  assign p1_inc     = p1_score_q + 4'd1;
  assign p2_inc     = p2_score_q + 4'd1;

  // Debounce: the filtered level follows the synchronised button only after
  // DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_comb begin
    ng_filt_d = ng_filt_q;
    deb_d     = '0;
    if (ng_sync2_q != ng_filt_q) begin
      if (deb_q == DEB_LAST) begin
        ng_filt_d = ng_sync2_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  // State register plus all other flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HOLD;
      pause_q     <= '0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      serve_req_q <= 1'b0;
      serve_dir_q <= 1'b0;
      winner_q    <= '0;
      p1_goal_q   <= 1'b0;
      p2_goal_q   <= 1'b0;
      ng_sync1_q  <= 1'b0;
      ng_sync2_q  <= 1'b0;
      ng_filt_q   <= 1'b0;
      ng_prev_q   <= 1'b0;
      deb_q       <= '0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      serve_req_q <= serve_req_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      p1_goal_q   <= p1_goal;
      p2_goal_q   <= p2_goal;
      ng_sync1_q  <= new_game;
      ng_sync2_q  <= ng_sync1_q;
      ng_filt_q   <= ng_filt_d;
      ng_prev_q   <= ng_filt_q;
      deb_q       <= deb_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ng_clear) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD: if (pause_done) state_d = PLAY;
        PLAY: begin
          // Simultaneous edges are a collision-logic fault: neither counts
          if (p1_edge && !p2_edge) begin
            state_d = (p1_inc == WIN) ? OVER : HOLD;
          end else if (p2_edge && !p1_edge) begin
            state_d = (p2_inc == WIN) ? OVER : HOLD;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = HOLD;
      endcase
    end
  end

  // Output / datapath logic.
  // Entering HOLD loads the pause counter with 1 so the serve fires
  // SERVE_DELAY edges later; the reset value of 0 pushes the first serve
  // after reset to SERVE_DELAY edges after the first active edge.
  always_comb begin
    pause_d     = pause_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    serve_req_d = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    if (ng_clear) begin
      p1_score_d  = '0;
      p2_score_d  = '0;
      serve_dir_d = 1'b0;
      winner_d    = '0;
      pause_d     = PAUSE_FIRST;
    end else begin
      case (state_q)
        HOLD: begin
          if (pause_done) serve_req_d = 1'b1;
          else            pause_d     = pause_q + 1'b1;
        end
        PLAY: begin
          if (p1_edge && !p2_edge) begin
            p1_score_d  = p1_inc;
            serve_dir_d = 1'b1;
            if (p1_inc == WIN) winner_d = 2'b01;
            else               pause_d  = PAUSE_FIRST;
          end else if (p2_edge && !p1_edge) begin
            p2_score_d  = p2_inc;
            serve_dir_d = 1'b0;
            if (p2_inc == WIN) winner_d = 2'b10;
            else               pause_d  = PAUSE_FIRST;
          end
        end
        default: ;
      endcase
    end
  end

  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign serve_req = serve_req_q;
  assign serve_dir = serve_dir_q;
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
module tb_pong_score_keeper;

  localparam int WIN = 3;
  localparam int SD  = 10;
  localparam int DB  = 4;

  localparam int S_HOLD = 0;
  localparam int S_PLAY = 1;
  localparam int S_OVER = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       p1_goal = 1'b0;
  logic       p2_goal = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] p1_score, p2_score;
  logic       serve_req, serve_dir, game_over;
  logic [1:0] winner;

  logic [12:0] dut_vec;
  assign dut_vec = {p1_score, p2_score, serve_req, serve_dir, game_over, winner};

  int checks = 0;
  int errors = 0;

  pong_score_keeper #(
    .WIN_SCORE(WIN),
    .SERVE_DELAY(SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .p1_goal(p1_goal),
    .p2_goal(p2_goal),
    .new_game(new_game),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .serve_req(serve_req),
    .serve_dir(serve_dir),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 CLK = ~CLK;

  // Reference model: absolute cycle numbers since reset, a history of raw
  // button samples, and serve deadlines computed as entry-edge + SD.
  int         m_cyc;
  int         m_due;
  int         m_state;
  logic [3:0] m_p1, m_p2;
  logic [1:0] m_win;
  bit         m_dir, m_serve, m_filt, m_rose, m_g1, m_g2;
  bit         hist[int];

  function automatic bit h(int n);
    if (hist.exists(n)) return hist[n];
    return 1'b0;
  endfunction

  function automatic logic [12:0] mvec();
    return {m_p1, m_p2, m_serve, m_dir, (m_state == S_OVER), m_win};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_due = SD + 1; m_state = S_HOLD;
    m_p1 = '0; m_p2 = '0; m_win = '0;
    m_dir = 0; m_serve = 0; m_filt = 0; m_rose = 0; m_g1 = 0; m_g2 = 0;
    hist.delete();
  endtask

  task automatic step(input logic g1, input logic g2, input logic ng);
    bit clear, flip, e1, e2;
    p1_goal = g1; p2_goal = g2; new_game = ng;
    @(posedge CLK);
    m_cyc++;
    hist[m_cyc] = ng;
    clear = m_rose;
    // filtered level flips once the last DB synchronised samples all disagree
    flip = 1;
    for (int j = 0; j < DB; j++) if (h(m_cyc - 2 - j) == m_filt) flip = 0;
    m_rose = flip && !m_filt;
    if (flip) m_filt = !m_filt;
    e1 = g1 && !m_g1; e2 = g2 && !m_g2;
    m_g1 = g1; m_g2 = g2;
    m_serve = 0;
    if (clear) begin
      m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
      m_state = S_HOLD; m_due = m_cyc + SD;
    end else if (m_state == S_HOLD) begin
      if (m_cyc == m_due) begin m_serve = 1; m_state = S_PLAY; end
    end else if (m_state == S_PLAY && (e1 != e2)) begin
      if (e1) begin
        m_p1 = m_p1 + 1; m_dir = 1;
        if (m_p1 == WIN) begin m_state = S_OVER; m_win = 2'b01; end
        else begin m_state = S_HOLD; m_due = m_cyc + SD; end
      end else begin
        m_p2 = m_p2 + 1; m_dir = 0;
        if (m_p2 == WIN) begin m_state = S_OVER; m_win = 2'b10; end
        else begin m_state = S_HOLD; m_due = m_cyc + SD; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 13'h0) begin
      errors++; $display("FAIL reset_values got %h expected %h", dut_vec, 13'h0);
    end
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_first_serve();
    int pulses = 0, at = -1;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL first_serve edge %0d got %h expected %h", i, dut_vec, mvec());
      end
      if (serve_req) begin pulses++; at = i; end
    end
    checks++;
    if (pulses != 1 || at != SD + 1) begin
      errors++; $display("FAIL first_serve_timing got %0d pulses at edge %0d expected 1 at edge %0d", pulses, at, SD + 1);
    end
  endtask

  task automatic test_held_goal();
    int pulses = 0, at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL held_goal cycle %0d got %h expected %h", i, dut_vec, mvec());
      end
      if (serve_req) begin pulses++; at = i; end
    end
    checks++;
    if (p1_score !== 4'd1 || p2_score !== 4'd0 || serve_dir !== 1'b1) begin
      errors++; $display("FAIL held_goal_result got p1=%0d p2=%0d dir=%b expected p1=1 p2=0 dir=1", p1_score, p2_score, serve_dir);
    end
    checks++;
    if (pulses != 1 || at != SD) begin
      errors++; $display("FAIL held_goal_serve got %0d pulses at offset %0d expected 1 at offset %0d", pulses, at, SD);
    end
    step(0, 0, 0);
  endtask

  task automatic test_game_to_win();
    int seq[3] = '{2, 1, 1};
    int pulses = 0;
    foreach (seq[k]) begin
      for (int i = 0; i < 30 && m_state != S_PLAY; i++) begin
        step(0, 0, 0);
        checks++;
        if (dut_vec !== mvec()) begin
          errors++; $display("FAIL game_wait goal %0d got %h expected %h", k, dut_vec, mvec());
        end
      end
      for (int w = $urandom_range(1, 5); w > 0; w--) begin
        step(seq[k] == 1, seq[k] == 2, 0);
        checks++;
        if (dut_vec !== mvec()) begin
          errors++; $display("FAIL game_goal goal %0d got %h expected %h", k, dut_vec, mvec());
        end
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(0, (i % 6) < 2, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL game_over_phase cycle %0d got %h expected %h", i, dut_vec, mvec());
      end
      if (serve_req) pulses++;
    end
    checks++;
    if (p1_score !== 4'd3 || p2_score !== 4'd1 || game_over !== 1'b1 || winner !== 2'b01 || pulses != 0) begin
      errors++; $display("FAIL game_final got %0d/%0d over=%b win=%b serves=%0d expected 3/1 over=1 win=01 serves=0",
                         p1_score, p2_score, game_over, winner, pulses);
    end
  endtask

  task automatic test_new_game_bounce();
    int clear_at = -1, serve_at = -1;
    for (int b = 0; b < 4; b++) begin
      for (int w = $urandom_range(1, 3); w > 0; w--) begin
        step(0, 0, 1);
        checks++;
        if (dut_vec !== mvec()) begin
          errors++; $display("FAIL bounce_high pulse %0d got %h expected %h", b, dut_vec, mvec());
        end
      end
      for (int w = $urandom_range(2, 4); w > 0; w--) begin
        step(0, 0, 0);
        checks++;
        if (dut_vec !== mvec()) begin
          errors++; $display("FAIL bounce_low pulse %0d got %h expected %h", b, dut_vec, mvec());
        end
      end
    end
    repeat (6) step(0, 0, 0);
    checks++;
    if (game_over !== 1'b1 || p1_score !== 4'd3) begin
      errors++; $display("FAIL bounce_no_clear got over=%b p1=%0d expected over=1 p1=3", game_over, p1_score);
    end
    for (int s = 0; s < 23; s++) begin
      step(0, 0, s < 8);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL new_game step %0d got %h expected %h", s, dut_vec, mvec());
      end
      if (clear_at < 0 && game_over === 1'b0) clear_at = s;
      if (serve_req && serve_at < 0) serve_at = s;
    end
    checks++;
    if (clear_at != DB + 2 || serve_at != DB + 2 + SD) begin
      errors++; $display("FAIL new_game_latency got clear %0d serve %0d expected clear %0d serve %0d",
                         clear_at, serve_at, DB + 2, DB + 2 + SD);
    end
    checks++;
    if (p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
      errors++; $display("FAIL new_game_clear got %0d/%0d win=%b over=%b expected 0/0 win=00 over=0",
                         p1_score, p2_score, winner, game_over);
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    for (int w = $urandom_range(1, 3); w > 0; w--) begin
      step(1, 1, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL simultaneous_high got %h expected %h", dut_vec, mvec());
      end
    end
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL simultaneous_idle cycle %0d got %h expected %h", i, dut_vec, mvec());
      end
      if (serve_req) pulses++;
    end
    step(0, 1, 0);
    checks++;
    if (pulses != 0 || p1_score !== 4'd0 || p2_score !== 4'd1) begin
      errors++; $display("FAIL simultaneous_result got serves=%0d %0d/%0d expected serves=0 0/1", pulses, p1_score, p2_score);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0, at = -1;
    for (int i = 0; i < 30 && m_state != S_PLAY; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL mid_hold_wait got %h expected %h", dut_vec, mvec());
      end
    end
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    checks++;
    if (dut_vec !== mvec()) begin
      errors++; $display("FAIL mid_hold_pre got %h expected %h", dut_vec, mvec());
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 13'h0) begin
      errors++; $display("FAIL mid_hold_async_reset got %h expected %h", dut_vec, 13'h0);
    end
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    model_reset();
    for (int i = 1; i <= 13; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL mid_hold_after edge %0d got %h expected %h", i, dut_vec, mvec());
      end
      if (serve_req) begin pulses++; at = i; end
    end
    checks++;
    if (pulses != 1 || at != SD + 1) begin
      errors++; $display("FAIL mid_hold_serve got %0d pulses at edge %0d expected 1 at edge %0d", pulses, at, SD + 1);
    end
  endtask

  task automatic test_random();
    int rem = 0, act = 0;
    logic g1, g2, ng;
    for (int c = 0; c < 1500; c++) begin
      if (rem == 0) begin
        act = $urandom_range(0, 9);
        if (act <= 5)      rem = $urandom_range(1, 8);
        else if (act <= 8) rem = $urandom_range(1, 4);
        else               rem = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(6, 10);
      end
      g1 = (act == 6 || act == 8);
      g2 = (act == 7 || act == 8);
      ng = (act == 9);
      step(g1, g2, ng);
      checks++;
      if (dut_vec !== mvec()) begin
        errors++; $display("FAIL random cycle %0d got %h expected %h", c, dut_vec, mvec());
      end
      rem--;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_serve();
    test_held_goal();
    test_game_to_win();
    test_new_game_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
